// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the RV32I pipeline sequencer:
//                sequencer state encoding and EX operand forwarding selects
//                (also used by the datapath operand muxes).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } hz_state_t;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Forwarding select for one EX source register; the younger MEM result
  // wins over WB, and x0 is never forwarded since it is hardwired to zero.
  function automatic logic [1:0] fwd_sel(
    input logic       mem_wr,
    input logic [4:0] mem_rd,
    input logic       wb_wr,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/haz_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : haz_sat_cnt
//  Description : Saturating event counter with enable; holds at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module haz_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count enabled cycles, stopping at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : haz_sat_cnt
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline sequencer for the 5-stage RV32I core. Produces
//                stage enables, flushes and bubbles, EX forwarding selects,
//                a post-reset flush window and data-memory wait handling
//                with a sticky timeout halt.
//                Optional macro HAZ_PERF_EN adds stall/flush counters;
//                without it the counter ports are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYC    = 4,
  parameter int MEM_TIMEOUT = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rs1,
  input  logic [4:0]        ex_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_memrd,
  input  logic              ex_regwr,
  input  logic              ex_redirect,
  input  logic [4:0]        mem_rd,
  input  logic              mem_regwr,
  input  logic [4:0]        wb_rd,
  input  logic              wb_regwr,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              pc_sel_redirect,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              memwb_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam int c_init_w = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int c_wait_w = $clog2(MEM_TIMEOUT + 1);

  hz_state_t             r_state, w_next_state;
  logic [c_init_w-1:0]   r_init_cnt, w_init_cnt_nxt;
  logic [c_wait_w-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic                  r_halted, w_halted_nxt;
  logic                  w_lu, w_mw, w_freeze;

  // Load-use hazard: ID reads a register the EX load has not produced yet
  assign w_lu = ex_memrd && ex_regwr && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_mw = mem_req && !mem_ready;

  assign fwd_a  = fwd_sel(mem_regwr, mem_rd, wb_regwr, wb_rd, ex_rs1);
  assign fwd_b  = fwd_sel(mem_regwr, mem_rd, wb_regwr, wb_rd, ex_rs2);
  assign halted = r_halted;

  // State, window counters and sticky halt flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_wait_cnt <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_init_cnt <= w_init_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  // Next state and stage controls; a freeze overrides redirect and load-use
  always_comb begin
    w_next_state    = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_halted_nxt    = r_halted;
    w_freeze        = 1'b0;
    pc_en           = 1'b1;
    ifid_en         = 1'b1;
    idex_en         = 1'b1;
    exmem_en        = 1'b1;
    pc_sel_redirect = 1'b0;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    memwb_bubble    = 1'b0;

    case (r_state)
      ST_INIT: begin
        pc_en        = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        if (r_init_cnt == c_init_w'(INIT_CYC - 1)) begin
          w_next_state   = ST_RUN;
          w_init_cnt_nxt = '0;
        end else begin
          w_init_cnt_nxt = r_init_cnt + c_init_w'(1);
        end
      end
      ST_RUN: begin
        if (w_mw) begin
          w_freeze       = 1'b1;
          w_next_state   = ST_MEM_WAIT;
          w_wait_cnt_nxt = c_wait_w'(1);
        end else if (ex_redirect) begin
          pc_sel_redirect = 1'b1;
          ifid_flush      = 1'b1;
          idex_bubble     = 1'b1;
        end else if (w_lu) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        w_freeze = 1'b1;
        if (mem_ready) begin
          w_next_state   = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == c_wait_w'(MEM_TIMEOUT)) begin
          w_next_state = ST_HALT;
          w_halted_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_wait_w'(1);
        end
      end
      ST_HALT: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_next_state = ST_INIT;
      end
    endcase

    if (w_freeze) begin
      pc_en           = 1'b0;
      ifid_en         = 1'b0;
      idex_en         = 1'b0;
      exmem_en        = 1'b0;
      pc_sel_redirect = 1'b0;
      ifid_flush      = 1'b0;
      idex_bubble     = 1'b0;
      memwb_bubble    = 1'b1;
    end
  end

`ifdef HAZ_PERF_EN
  logic w_stall_ev, w_flush_ev;

  // Stalls are counted while running or waiting on memory, flushes only in RUN
  assign w_stall_ev = !pc_en && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT));
  assign w_flush_ev = ifid_flush && (r_state == ST_RUN);

  haz_sat_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_stall_ev),
    .cnt   (stall_cnt)
  );

  haz_sat_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_flush_ev),
    .cnt   (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: directed hazard
//                scenarios plus randomized traffic against a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int INIT_CYC    = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int PERF_W      = 32;

  localparam int M_INIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_memrd, ex_regwr, ex_redirect;
  logic mem_regwr, wb_regwr, mem_req, mem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, pc_sel_redirect;
  logic ifid_flush, idex_bubble, memwb_bubble, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .INIT_CYC    (INIT_CYC),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .PERF_W      (PERF_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_memrd        (ex_memrd),
    .ex_regwr        (ex_regwr),
    .ex_redirect     (ex_redirect),
    .mem_rd          (mem_rd),
    .mem_regwr       (mem_regwr),
    .wb_rd           (wb_rd),
    .wb_regwr        (wb_regwr),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .pc_sel_redirect (pc_sel_redirect),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .memwb_bubble    (memwb_bubble),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int      m_mode;
  int      m_init_seen;
  int      m_wait;
  bit      m_halted;
  longint  m_stall, m_flush;
  logic [7:0] e_ctl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (mem_regwr && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
    if (wb_regwr && wb_rd != 5'd0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Expected control vector:
  // {pc_en, ifid_en, idex_en, exmem_en, pc_sel_redirect, ifid_flush, idex_bubble, memwb_bubble}
  task automatic model_outputs();
    bit lu, mw;
    lu = ex_memrd && ex_regwr && ex_rd != 5'd0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mw = mem_req && !mem_ready;
    if (m_mode == M_INIT)                         e_ctl = 8'b0111_0111;
    else if (m_mode != M_RUN || mw)               e_ctl = 8'b0000_0001;
    else if (ex_redirect)                         e_ctl = 8'b1111_1110;
    else if (lu)                                  e_ctl = 8'b0011_0010;
    else                                          e_ctl = 8'b1111_0000;
  endtask

  task automatic model_step();
    bit mw;
    mw = mem_req && !mem_ready;
    if (!e_ctl[7] && (m_mode == M_RUN || m_mode == M_WAIT)) m_stall++;
    if (e_ctl[2] && m_mode == M_RUN) m_flush++;
    case (m_mode)
      M_INIT: begin
        m_init_seen++;
        if (m_init_seen == INIT_CYC) m_mode = M_RUN;
      end
      M_RUN: if (mw) begin m_mode = M_WAIT; m_wait = 1; end
      M_WAIT: begin
        if (mem_ready) m_mode = M_RUN;
        else if (m_wait == MEM_TIMEOUT) begin m_mode = M_HALT; m_halted = 1'b1; end
        else m_wait++;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    model_outputs();
    chk("ctl", {pc_en, ifid_en, idex_en, exmem_en, pc_sel_redirect,
                ifid_flush, idex_bubble, memwb_bubble}, e_ctl);
    chk("fwd_a", fwd_a, fwd_ref(ex_rs1));
    chk("fwd_b", fwd_b, fwd_ref(ex_rs2));
    chk("halted", halted, m_halted);
`ifdef HAZ_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`else
    chk("stall_cnt", stall_cnt, 0);
    chk("flush_cnt", flush_cnt, 0);
`endif
  endtask

  // Inputs already applied at posedge+1; check, then advance one edge
  task automatic do_cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must return to INIT at once
  task automatic do_reset();
    rst_n       = 1'b0;
    m_mode      = M_INIT;
    m_init_seen = 0;
    m_wait      = 0;
    m_halted    = 1'b0;
    m_stall     = 0;
    m_flush     = 0;
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memrd = 0; ex_regwr = 0;
    ex_redirect = 0; mem_rd = 0; mem_regwr = 0; wb_rd = 0; wb_regwr = 0;
    mem_req = 0; mem_ready = 1;
  endtask

  task automatic rand_inputs(input int low_pct);
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_use_rs1  = 1'($urandom_range(0, 1));
    id_use_rs2  = 1'($urandom_range(0, 1));
    ex_rs1      = 5'($urandom_range(0, 3));
    ex_rs2      = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    ex_memrd    = ($urandom_range(0, 2) == 0);
    ex_regwr    = 1'($urandom_range(0, 1));
    ex_redirect = ($urandom_range(0, 7) == 0);
    mem_rd      = 5'($urandom_range(0, 3));
    mem_regwr   = 1'($urandom_range(0, 1));
    wb_rd       = 5'($urandom_range(0, 3));
    wb_regwr    = 1'($urandom_range(0, 1));
    mem_req     = ($urandom_range(0, 2) == 0);
    mem_ready   = ($urandom_range(0, 99) >= low_pct);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Post-reset flush window, then normal running
    for (int i = 0; i < INIT_CYC + 2; i++) do_cycle();

    // Load-use on rs1, then the same with ex_rd = x0
    ex_memrd = 1; ex_regwr = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    do_cycle();
    idle(); do_cycle();
    ex_memrd = 1; ex_regwr = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    do_cycle();

    // Redirect and load-use in the same cycle
    ex_memrd = 1; ex_regwr = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; ex_redirect = 1;
    do_cycle();
    idle(); do_cycle();

    // Memory wait that completes just before the timeout
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) do_cycle();
    mem_ready = 1;
    do_cycle();
    idle(); do_cycle(); do_cycle();

    // Memory wait that times out; the halt is sticky until reset
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) do_cycle();
    mem_ready = 1; ex_redirect = 1;
    for (int i = 0; i < 3; i++) do_cycle();
    idle();
    do_reset();
    for (int i = 0; i < INIT_CYC + 1; i++) do_cycle();

    // Forwarding priority
    ex_rs1 = 3; ex_rs2 = 3; mem_rd = 3; wb_rd = 3; mem_regwr = 1; wb_regwr = 1;
    do_cycle();
    mem_regwr = 0; do_cycle();
    mem_rd = 0; wb_rd = 0; mem_regwr = 1; do_cycle();
    idle();

    // Randomized traffic with periodic resets
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 150; i++) begin
        rand_inputs(blk == 3 ? 85 : 30);
        do_cycle();
      end
      idle();
      do_reset();
    end
    for (int i = 0; i < INIT_CYC + 1; i++) do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
